// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between requesters and the tristate bus arbiter.
// The arbiter takes the master view; requesters take the slave view.
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  en;
    logic [IW-1:0] gnt_id;
    logic          busy;

    modport master (
        input  req,
        output en,
        output gnt_id,
        output busy
    );

    modport slave (
        output req,
        input  en,
        input  gnt_id,
        input  busy
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate wire.
// Enables are one-hot or zero, with all-off turnaround between owners.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    tristate_bus_arbiter_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [N-1:0]  en_q, en_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] rr_ptr, rr_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [TW-1:0] turn_cnt, turn_d;

    logic          win_vld;
    logic [IW-1:0] win_id;
    logic [N-1:0]  win_oh;
    logic [N-1:0]  own_oh;
    logic          others;
    logic          hold_max;
    logic          release_now;
    int            idx;

    // Descending offset so the nearest requester past rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N;
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = IW'(idx);
            end
        end
        win_oh         = '0;
        win_oh[win_id] = 1'b1;
        own_oh         = '0;
        own_oh[gnt_q]  = 1'b1;
    end

    assign others      = |(bus.req & ~own_oh);
    assign hold_max    = (hold_cnt == HW'(HOLD_MAX - 1));
    assign release_now = !bus.req[gnt_q] || (hold_max && others);

    always_comb begin
        state_d = state;
        en_d    = en_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        rr_d    = rr_ptr;
        hold_d  = hold_cnt;
        turn_d  = turn_cnt;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    en_d    = win_oh;
                    gnt_d   = win_id;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = TURN;
                    en_d    = '0;
                    busy_d  = 1'b0;
                    turn_d  = '0;
                    rr_d    = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
                end else if (!hold_max) begin
                    hold_d  = hold_cnt + HW'(1);
                end
            end
            TURN: begin
                if (turn_cnt == TW'(TURN_CYC - 1)) begin
                    if (win_vld) begin
                        state_d = GRANT;
                        en_d    = win_oh;
                        gnt_d   = win_id;
                        busy_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            en_q     <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_d;
            en_q     <= en_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            rr_ptr   <= rr_d;
            hold_cnt <= hold_d;
            turn_cnt <= turn_d;
        end
    end

    assign bus.en     = en_q;
    assign bus.gnt_id = gnt_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed and random-invariant bench for tristate_bus_arbiter.
module tb_tristate_bus_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tristate_bus_arbiter_if #(.N(N)) bus ();

    tristate_bus_arbiter #(
        .N(N),
        .HOLD_MAX(8),
        .TURN_CYC(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_en,
                           input logic e_busy);
        chk({tag, "_en"}, 32'(bus.en), 32'(e_en));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(e_busy));
    endtask

    // Behavioural model of the shared wire: each requester drives 8'h10+i.
    function automatic logic [7:0] wire_val(input logic [3:0] en);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < N; i++)
            if (en[i]) v = v | (8'h10 + 8'(i));
        return v;
    endfunction

    logic [3:0] prev_en;
    logic [3:0] oh;

    initial begin
        bus.req = 4'b1111;
        rst_n   = 1'b0;

        // reset with all requests high
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out("reset", 4'b0000, 1'b0);
            chk("reset_gnt", 32'(bus.gnt_id), 32'd0);
        end

        // single requester 2, then drop
        rst_n   = 1'b1;
        bus.req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_out("single2", 4'b0100, 1'b1);
            chk("single2_gnt", 32'(bus.gnt_id), 32'd2);
        end
        bus.req = 4'b0000;
        tick();
        chk_out("drop2", 4'b0000, 1'b0);
        chk("drop2_gnt_hold", 32'(bus.gnt_id), 32'd2);
        tick();
        chk_out("turn2", 4'b0000, 1'b0);
        tick();
        chk_out("idle2", 4'b0000, 1'b0);

        // lone requester 1 is never preempted
        bus.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_out("lone1", 4'b0010, 1'b1);
        end
        bus.req = 4'b0000;
        tick();
        chk_out("lone1_rel", 4'b0000, 1'b0);
        tick();
        chk_out("lone1_turn", 4'b0000, 1'b0);

        // reset during grant to owner 2
        bus.req = 4'b0100;
        tick();
        chk_out("pre_rst", 4'b0100, 1'b1);
        tick();
        chk_out("pre_rst2", 4'b0100, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_out("rst_grant", 4'b0000, 1'b0);
        chk("rst_grant_gnt", 32'(bus.gnt_id), 32'd0);

        // all request: 0,1,2,3 for 8 cycles each, 1 gap, then 0 again
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int o = 0; o < N; o++) begin
            oh = 4'b0001 << o;
            for (int c = 0; c < 8; c++) begin
                tick();
                chk_out($sformatf("rr_o%0d_c%0d", o, c), oh, 1'b1);
                chk($sformatf("rr_o%0d_gnt", o), 32'(bus.gnt_id), 32'(o));
            end
            tick();
            chk_out($sformatf("rr_gap%0d", o), 4'b0000, 1'b0);
        end
        tick();
        chk_out("rr_wrap0", 4'b0001, 1'b1);

        // req drops in the first grant cycle: grant still lasts 1 cycle
        bus.req = 4'b0000;
        tick();
        chk_out("short_rel", 4'b0000, 1'b0);
        tick();
        chk_out("short_idle", 4'b0000, 1'b0);

        // same owner re-grant passes through TURN
        bus.req = 4'b0010;
        tick();
        chk_out("same1_a", 4'b0010, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk_out("same1_rel", 4'b0000, 1'b0);
        bus.req = 4'b0010;
        tick();
        chk_out("same1_b", 4'b0010, 1'b1);

        // random requests with invariant checks on the shared wire
        prev_en = bus.en;
        for (int c = 0; c < 1000; c++) begin
            bus.req = 4'($urandom_range(0, 15));
            tick();
            chk("rnd_onehot", 32'($countones(bus.en) <= 1), 32'd1);
            chk("rnd_busy", 32'(bus.busy), 32'(|bus.en));
            chk("rnd_turnaround",
                32'(prev_en != 4'b0000 && bus.en != 4'b0000
                    && prev_en != bus.en), 32'd0);
            if (bus.busy)
                chk("rnd_wire", 32'(wire_val(bus.en)),
                    32'(8'h10 + 8'(bus.gnt_id)));
            prev_en = bus.en;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
